scr1_tb_test_monitor: RTL and testbench

SCR1_TB_TEST_MONITOR -- requirements
Module: scr1_tb_test_monitor

---
 rtl/scr1_tb_test_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_scr1_tb_test_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_test_monitor.sv
// Simulation test-exit monitor for the SCR1 testbench.
// Watches retired PCs for a configurable set of exit addresses, confirms an
// exit after HIT_CYCLES consecutive matching retirements on the same channel,
// and reports the verdict from a0 (x10 == 0 means pass).
// Optional watchdog is compiled in with macro SCR1_TB_MON_TIMEOUT_EN.
module scr1_tb_test_monitor #(
  parameter int XLEN           = 32,
  parameter int EXIT_NUM       = 2,
  parameter int HIT_CYCLES     = 1,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [EXIT_NUM*XLEN-1:0]               exit_addr,
  input  logic [EXIT_NUM-1:0]                    exit_en,
  input  logic                                   pc_vd,
  input  logic [XLEN-1:0]                        pc,
  input  logic [XLEN-1:0]                        a0,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   pass,
  output logic                                   timeout,
  output logic [((EXIT_NUM > 1) ? $clog2(EXIT_NUM) : 1)-1:0] exit_idx,
  output logic [CNT_WIDTH-1:0]                   cycle_cnt
);

  localparam int IDXW  = (EXIT_NUM > 1) ? $clog2(EXIT_NUM) : 1;
  localparam int HIT_W = 4;

  // Elaboration-time parameter sanity checks.
  if (EXIT_NUM < 1 || EXIT_NUM > 8) begin : g_bad_exit_num
    $error("scr1_tb_test_monitor: EXIT_NUM must be in 1..8");
  end
  if (HIT_CYCLES < 1 || HIT_CYCLES > 15) begin : g_bad_hit_cycles
    $error("scr1_tb_test_monitor: HIT_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("scr1_tb_test_monitor: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [IDXW-1:0]      hit_ch_q, hit_ch_d;
  logic [IDXW-1:0]      exit_idx_q, exit_idx_d;
  logic                 pass_q, pass_d;
`ifdef SCR1_TB_MON_TIMEOUT_EN
  logic                 timeout_q, timeout_d;
`endif

  logic                 hit_any;
  logic [IDXW-1:0]      hit_ch;
  logic [HIT_W-1:0]     hit_cnt_nxt;
  logic                 confirm;
  logic                 wdog;

  // Lowest-index enabled channel whose address matches the retired PC.
  always_comb begin
    hit_any = 1'b0;
    hit_ch  = '0;
    for (int unsigned i = 0; i < EXIT_NUM; i++) begin
      if (!hit_any && exit_en[i] && (pc == exit_addr[i*XLEN +: XLEN])) begin
        hit_any = 1'b1;
        hit_ch  = IDXW'(i);
      end
    end
  end

  // Streak length after this sample; a new channel restarts the streak at 1.
  always_comb begin
    if (!hit_any) begin
      hit_cnt_nxt = '0;
    end else if ((hit_cnt_q != '0) && (hit_ch == hit_ch_q)) begin
      hit_cnt_nxt = hit_cnt_q + HIT_W'(1);
    end else begin
      hit_cnt_nxt = HIT_W'(1);
    end
    confirm = (state_q == ST_RUN) && pc_vd && hit_any &&
              (hit_cnt_nxt == HIT_W'(HIT_CYCLES));
  end

`ifdef SCR1_TB_MON_TIMEOUT_EN
  localparam longint unsigned TO_LIM = 64'(TIMEOUT_CYCLES) - 64'd1;
  // Watchdog fires on the cycle whose count has reached the limit.
  always_comb begin
    wdog = (state_q == ST_RUN) && (64'(cycle_cnt_q) >= TO_LIM);
  end
`else
  assign wdog = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      hit_cnt_q   <= '0;
      hit_ch_q    <= '0;
      exit_idx_q  <= '0;
      pass_q      <= 1'b0;
`ifdef SCR1_TB_MON_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_ch_q    <= hit_ch_d;
      exit_idx_q  <= exit_idx_d;
      pass_q      <= pass_d;
`ifdef SCR1_TB_MON_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state logic: start (re)arms from any state and beats a confirmation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (confirm || wdog) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: counters, streak tracking and verdict capture.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    hit_ch_d    = hit_ch_q;
    exit_idx_d  = exit_idx_q;
    pass_d      = pass_q;
`ifdef SCR1_TB_MON_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    if (start) begin
      cycle_cnt_d = '0;
      hit_cnt_d   = '0;
      hit_ch_d    = '0;
      exit_idx_d  = '0;
      pass_d      = 1'b0;
`ifdef SCR1_TB_MON_TIMEOUT_EN
      timeout_d   = 1'b0;
`endif
    end else if (state_q == ST_RUN) begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
      end
      if (pc_vd) begin
        hit_cnt_d = hit_cnt_nxt;
        hit_ch_d  = hit_ch;
      end
      // Exit confirmation outranks a coincident watchdog expiry.
      if (confirm) begin
        exit_idx_d = hit_ch;
        pass_d     = (a0 == '0);
`ifdef SCR1_TB_MON_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif
      end else if (wdog) begin
        pass_d     = 1'b0;
`ifdef SCR1_TB_MON_TIMEOUT_EN
        timeout_d  = 1'b1;
`endif
      end
    end
  end

  // Output decode.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    pass      = pass_q;
    exit_idx  = exit_idx_q;
    cycle_cnt = cycle_cnt_q;
  end

`ifdef SCR1_TB_MON_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_tb_test_monitor.sv
// Self-checking bench for scr1_tb_test_monitor: two instances (HIT_CYCLES 1
// with a 32-bit counter, HIT_CYCLES 3 with a 6-bit saturating counter) share
// stimulus and are compared every cycle against a history-based model.
module tb_scr1_tb_test_monitor;

  localparam int XLEN     = 32;
  localparam int EXIT_NUM = 3;
  localparam int IDXW     = 2;
  localparam int TO_CYC   = 50;
  localparam int HC [2]   = '{1, 3};
  localparam int CW [2]   = '{32, 6};
`ifdef SCR1_TB_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     start = 1'b0;
  logic [EXIT_NUM*XLEN-1:0] exit_addr = '0;
  logic [EXIT_NUM-1:0]      exit_en = '0;
  logic                     pc_vd = 1'b0;
  logic [XLEN-1:0]          pc = '0;
  logic [XLEN-1:0]          a0 = '0;

  logic            busy0, done0, pass0, to0;
  logic [IDXW-1:0] idx0;
  logic [31:0]     cnt0;
  logic            busy1, done1, pass1, to1;
  logic [IDXW-1:0] idx1;
  logic [5:0]      cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_tb_test_monitor #(
    .XLEN(XLEN), .EXIT_NUM(EXIT_NUM), .HIT_CYCLES(1), .CNT_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exit_addr(exit_addr), .exit_en(exit_en),
    .pc_vd(pc_vd), .pc(pc), .a0(a0), .busy(busy0), .done(done0), .pass(pass0),
    .timeout(to0), .exit_idx(idx0), .cycle_cnt(cnt0)
  );

  scr1_tb_test_monitor #(
    .XLEN(XLEN), .EXIT_NUM(EXIT_NUM), .HIT_CYCLES(3), .CNT_WIDTH(6), .TIMEOUT_CYCLES(TO_CYC)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .exit_addr(exit_addr), .exit_en(exit_en),
    .pc_vd(pc_vd), .pc(pc), .a0(a0), .busy(busy1), .done(done1), .pass(pass1),
    .timeout(to1), .exit_idx(idx1), .cycle_cnt(cnt1)
  );

  // Reference model: mode 0 idle / 1 running / 2 finished; the streak is
  // derived from the history of hit channels recorded since the last start.
  int              m_st   [2];
  longint unsigned m_cnt  [2];
  bit              m_pass [2];
  bit              m_to   [2];
  int              m_idx  [2];
  int              m_hist [2][$];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_pass[k] = 0; m_to[k] = 0; m_idx[k] = 0;
      m_hist[k].delete();
    end
  endfunction

  function automatic int first_hit();
    for (int i = 0; i < EXIT_NUM; i++)
      if (exit_en[i] && pc == exit_addr[i*XLEN +: XLEN]) return i;
    return -1;
  endfunction

  function automatic void model_step();
    int ch;
    ch = first_hit();
    for (int k = 0; k < 2; k++) begin
      longint unsigned old;
      longint unsigned maxc;
      int run;
      bit fin;
      old  = m_cnt[k];
      maxc = (64'd1 << CW[k]) - 64'd1;
      run  = 0;
      fin  = 0;
      if (start) begin
        m_st[k] = 1; m_cnt[k] = 0; m_pass[k] = 0; m_to[k] = 0; m_idx[k] = 0;
        m_hist[k].delete();
      end else if (m_st[k] == 1) begin
        if (m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
        if (pc_vd) begin
          m_hist[k].push_back(ch);
          if (ch >= 0)
            for (int j = m_hist[k].size() - 1; j >= 0 && m_hist[k][j] == ch; j--) run++;
          if (ch >= 0 && run == HC[k]) begin
            m_st[k] = 2; m_idx[k] = ch; m_pass[k] = (a0 == 0); m_to[k] = 0; fin = 1;
          end
          if (m_hist[k].size() > 16) void'(m_hist[k].pop_front());
        end
        if (TO_EN && !fin && old >= 64'(TO_CYC - 1)) begin
          m_st[k] = 2; m_to[k] = 1; m_pass[k] = 0;
        end
      end
    end
  endfunction

  function automatic logic [37:0] exp_vec(int k);
    return {m_st[k] == 1, m_st[k] == 2, m_pass[k], m_to[k], 2'(m_idx[k]), 32'(m_cnt[k])};
  endfunction

  function automatic logic [37:0] obs(int k);
    if (k == 0) return {busy0, done0, pass0, to0, idx0, cnt0};
    return {busy1, done1, pass1, to1, idx1, 26'd0, cnt1};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_ch(int i, logic [31:0] addr);
    exit_addr[i*XLEN +: XLEN] = addr;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    start = 1'b1;
    repeat (3) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset inst%0d got %h want %h", k, obs(k), exp_vec(k));
        end
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL first_start inst%0d got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_exit_seq(string name, logic [31:0] a0_val);
    logic [31:0] seq [3];
    seq = '{32'h100, 32'h104, 32'h200};
    set_ch(0, 32'h200); set_ch(1, 32'h900); set_ch(2, 32'h904);
    exit_en = 3'b001;
    a0 = a0_val;
    pulse_start();
    for (int n = 0; n < 6; n++) begin
      pc_vd = (n < 3);
      pc    = (n < 3) ? seq[n] : 32'h0;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL %s[%0d] inst%0d got %h want %h", name, n, k, obs(k), exp_vec(k));
        end
      end
    end
    pc_vd = 1'b0;
  endtask

  task automatic test_priority();
    logic [2:0] ens [2];
    ens = '{3'b011, 3'b010};
    set_ch(0, 32'h300); set_ch(1, 32'h300); set_ch(2, 32'h300);
    a0 = '0;
    for (int e = 0; e < 2; e++) begin
      exit_en = ens[e];
      pulse_start();
      pc = 32'h300;
      pc_vd = 1'b1;
      repeat (3) tick();
      pc_vd = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL priority[%0d] inst%0d got %h want %h", e, k, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_hit_streak();
    logic [31:0] seq [6];
    seq = '{32'h300, 32'h300, 32'h104, 32'h300, 32'h300, 32'h300};
    set_ch(0, 32'h700); set_ch(1, 32'h300); set_ch(2, 32'h704);
    exit_en = 3'b111;
    a0 = '0;
    pulse_start();
    for (int n = 0; n < 8; n++) begin
      pc_vd = (n < 6) && (n != 4 || 1'b1);
      pc    = (n < 6) ? seq[n] : 32'h0;
      if (n == 6) pc_vd = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL streak[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
    end
    pc_vd = 1'b0;
  endtask

  task automatic test_start_wins();
    set_ch(0, 32'h200);
    exit_en = 3'b001;
    a0 = '0;
    pulse_start();
    pc = 32'h200;
    pc_vd = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL start_wins[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
    end
    pc_vd = 1'b0;
  endtask

  task automatic test_timeout();
    exit_en = '0;
    pc_vd = 1'b0;
    pulse_start();
    for (int n = 0; n < 72; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL no_hit_run[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
    end
    set_ch(0, 32'h500);
    exit_en = 3'b001;
    a0 = '0;
    pulse_start();
    repeat (TO_CYC - 1) tick();
    pc = 32'h500;
    pc_vd = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      pc_vd = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL final_cycle_hit[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    exit_en = '0;
    pulse_start();
    repeat (20) tick();
    #3 rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL async_reset inst%0d got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    pulse_start();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL restart_after_reset[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    pool = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int i = 0; i < EXIT_NUM; i++) set_ch(i, pool[$urandom_range(0, 3)]);
    exit_en = 3'($urandom);
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 59) == 0);
      pc_vd = ($urandom_range(0, 3) != 0);
      pc    = pool[$urandom_range(0, 3)];
      a0    = $urandom_range(0, 1) ? 32'h0 : 32'($urandom_range(1, 255));
      if ($urandom_range(0, 29) == 0) exit_en = 3'($urandom);
      if ($urandom_range(0, 99) == 0) set_ch($urandom_range(0, EXIT_NUM - 1), pool[$urandom_range(0, 3)]);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random[%0d] inst%0d got %h want %h", n, k, obs(k), exp_vec(k));
        end
      end
    end
    start = 1'b0;
    pc_vd = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exit_seq("exit_pass", 32'h0);
    test_exit_seq("exit_fail", 32'h5);
    test_priority();
    test_hit_streak();
    test_start_wins();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
